// File: rtl/shift_seq_pkg.sv
// Shared constants for the multi-cycle shift sequencer: op encodings, FSM states, default widths.
package shift_seq_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned AMT_W_DEF = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One logarithmic shift stage: shifts by 2^k with op-dependent fill, or passes data through.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AMT_W = AMT_W_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] k,
    input  logic             enable,
    input  logic [1:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted_c
);

    logic [WIDTH-1:0] dist_c;
    logic [WIDTH-1:0] fill_c;

    // Arithmetic fill uses the sign captured at accept, not the current MSB
    always_comb begin
        dist_c    = WIDTH'(1) << k;
        fill_c    = sign ? ~({WIDTH{1'b1}} >> dist_c) : '0;
        shifted_c = data;
        if (enable) begin
            case (op)
                OP_SLL:  shifted_c = data << dist_c;
                OP_SRL:  shifted_c = data >> dist_c;
                OP_SRA:  shifted_c = (data >> dist_c) | fill_c;
                default: shifted_c = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one shared shift_step applied once per clock under a valid/ready FSM.
// SHIFT_SEQ_SKIP_EN: visit only the set amount bits (latency = popcount(amt)) instead of all stages.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned AMT_W  = AMT_W_DEF,
    parameter int unsigned NSTAGE = AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [AMT_W-1:0] amt, amt_nx;
    logic [1:0]       op, op_nx;
    logic             sign, sign_nx;
    logic             in_ready_nx, out_valid_nx, busy_nx;
    logic [WIDTH-1:0] out_data_nx;
    logic [WIDTH-1:0] step_c;
    logic [AMT_W-1:0] step_k_c;
    logic             step_en_c;

`ifdef SHIFT_SEQ_SKIP_EN
    logic [AMT_W-1:0] low_idx_c;
    logic [AMT_W-1:0] amt_clr_c;

    // Lowest remaining set bit of the amount selects this cycle's stage
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
            if (amt[i]) low_idx_c = AMT_W'(i);
        end
    end

    assign amt_clr_c = amt & (amt - AMT_W'(1));
    assign step_k_c  = low_idx_c;
    assign step_en_c = 1'b1;
`else
    localparam int unsigned STG_W = $clog2(NSTAGE);

    logic [STG_W-1:0] stage, stage_nx;

    assign step_k_c  = AMT_W'(stage);
    assign step_en_c = amt[stage];
`endif

    shift_step #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_step (
        .data      (work),
        .k         (step_k_c),
        .enable    (step_en_c),
        .op        (op),
        .sign      (sign),
        .shifted_c (step_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            work      <= '0;
            amt       <= '0;
            op        <= OP_SLL;
            sign      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
`ifndef SHIFT_SEQ_SKIP_EN
            stage     <= '0;
`endif
        end else begin
            state     <= state_nx;
            work      <= work_nx;
            amt       <= amt_nx;
            op        <= op_nx;
            sign      <= sign_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            busy      <= busy_nx;
            out_data  <= out_data_nx;
`ifndef SHIFT_SEQ_SKIP_EN
            stage     <= stage_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        work_nx      = work;
        amt_nx       = amt;
        op_nx        = op;
        sign_nx      = sign;
        in_ready_nx  = in_ready;
        out_valid_nx = out_valid;
        busy_nx      = busy;
        out_data_nx  = out_data;
`ifndef SHIFT_SEQ_SKIP_EN
        stage_nx     = stage;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    work_nx     = in_data;
                    amt_nx      = in_amt;
                    op_nx       = in_op;
                    sign_nx     = in_data[WIDTH-1];
                    in_ready_nx = 1'b0;
                    busy_nx     = 1'b1;
                    state_nx    = SHIFT;
`ifdef SHIFT_SEQ_SKIP_EN
                    if (in_amt == '0) begin
                        state_nx     = DONE;
                        out_valid_nx = 1'b1;
                        out_data_nx  = in_data;
                    end
`else
                    stage_nx    = '0;
`endif
                end
            end
            SHIFT: begin
                work_nx = step_c;
`ifdef SHIFT_SEQ_SKIP_EN
                amt_nx = amt_clr_c;
                if (amt_clr_c == '0) begin
`else
                stage_nx = stage + STG_W'(1);
                if (stage == STG_W'(NSTAGE - 1)) begin
`endif
                    state_nx     = DONE;
                    out_valid_nx = 1'b1;
                    out_data_nx  = step_c;
                end
            end
            DONE: begin
                // in_ready returns only after the handshake edge, so no same-edge re-accept
                if (out_ready) begin
                    state_nx     = IDLE;
                    out_valid_nx = 1'b0;
                    in_ready_nx  = 1'b1;
                    busy_nx      = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; expected latency follows SHIFT_SEQ_SKIP_EN when defined.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests;
    int          n_fail;
    int          cyc;

    logic        acc_q;
    logic        hs_q;
    logic        ov_q;
    int          acc_cyc;
    logic [31:0] held;
    exp_t        e;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] amt);
`ifdef SHIFT_SEQ_SKIP_EN
        return $countones(amt);
`else
        return 5;
`endif
    endfunction

    // Drive one request and queue its hand-computed result
    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o,
                        input logic [31:0] res);
        bit   done;
        exp_t x;
        x.data = res;
        x.lat  = exp_lat(a);
        exp_q.push_back(x);
        in_data  = d;
        in_amt   = a;
        in_op    = o;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout: request %h not accepted, required accept within 60 cycles", d);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each result, checks latency, hold-stability and handshake recovery
    initial begin
        acc_q = 1'b0;
        hs_q  = 1'b0;
        ov_q  = 1'b0;
        acc_cyc = 0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_q = 1'b0;
                hs_q  = 1'b0;
                ov_q  = 1'b0;
            end else begin
                if (acc_q) acc_cyc = cyc;
                if (hs_q) begin
                    check("in_ready_after_hs", 32'(in_ready), 32'd1);
                    check("out_valid_after_hs", 32'(out_valid), 32'd0);
                end
                if (out_valid && !ov_q) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got out_valid with data %h, required no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    end
                    held = out_data;
                end else if (out_valid) begin
                    check("out_data_hold", out_data, held);
                end
                acc_q = in_valid && in_ready;
                hs_q  = out_valid && out_ready;
                ov_q  = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        send(32'h0000_0001, 5'd8, 2'b00, 32'h0000_0100);
        drain();
        send(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        drain();
        send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
        drain();
        send(32'hDEAD_BEEF, 5'd7, 2'b11, 32'hDEAD_BEEF);
        drain();
        send(32'h8000_0000, 5'd5, 2'b10, 32'hFC00_0000);
        drain();
        send(32'hFFFF_FFFF, 5'd16, 2'b01, 32'h0000_FFFF);
        drain();

        // Backpressure with a stray request while the result is held
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd4, 2'b00, 32'h2345_6780);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_data  = 32'hFFFF_FFFF;
            in_amt   = 5'd1;
            in_op    = 2'b01;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during the third SHIFT cycle discards the request
        send(32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000);
        repeat (2) @(posedge clk);
        #1;
        check("busy_shift", 32'(busy), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back requests
        send(32'h8000_0001, 5'd1, 2'b00, 32'h0000_0002);
        send(32'h8000_0001, 5'd1, 2'b01, 32'h4000_0000);
        drain();

        // Amount boundaries: zero, sparse, all ones
        send(32'h0000_00A5, 5'd0, 2'b00, 32'h0000_00A5);
        drain();
        send(32'h0000_0001, 5'b10001, 2'b00, 32'h0002_0000);
        drain();
        send(32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
